// File: rtl/spi_word_host.sv
// spi_word_host -- SPI initiator (mode 0) that moves one p_nbits word per
// cs-low frame and returns the word captured on miso over a val/rdy port.
//
// Handshakes: a transfer happens on a rising clk edge where both val and rdy
// are high. req_rdy is high only in IDLE and never while rst is high. resp_val
// stays high with resp_msg stable until resp_rdy is seen. A req_val that
// arrives while busy is ignored, not queued.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   req_val/rdy/msg     word to transmit, MSB first
//   resp_val/rdy/msg    word received on miso, MSB first
//   cs, sclk, mosi      SPI outputs (all registered), cs active-low
//   miso                SPI input, assumed already synchronised by the caller
//   busy                high in every state except IDLE
//   dbg_state           current FSM state, for observation only
module spi_word_host #(
  parameter int p_nbits   = 32,
  parameter int p_clk_div = 4,
  parameter int p_cs_gap  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [p_nbits-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_msg,
  output logic               cs,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int CW = $clog2(p_clk_div + 1);
  localparam int BW = $clog2(p_nbits + 1);
  localparam int GW = $clog2(p_cs_gap + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(p_clk_div - 1);
  localparam logic [BW-1:0] NBITS    = BW'(p_nbits);
  localparam logic [GW-1:0] GAP_LAST = GW'(p_cs_gap - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_GAP   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [p_nbits-1:0] tx_q, tx_d;
  logic [p_nbits-1:0] rx_q, rx_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               resp_val_q, resp_val_d;
  logic               half_done;

  assign req_rdy   = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign resp_val  = resp_val_q;
  assign resp_msg  = rx_q;
  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign dbg_state = state_q;
  assign half_done = (cnt_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    resp_val_d = resp_val_q;
    case (state_q)
      S_IDLE: begin
        if (req_val && req_rdy) begin
          tx_d    = req_msg;
          rx_d    = '0;
          bit_d   = '0;
          cnt_d   = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = req_msg[p_nbits-1];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (half_done) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (half_done) begin
          cnt_d   = '0;
          rx_d    = {rx_q[p_nbits-2:0], miso};
          bit_d   = bit_q + BW'(1);
          sclk_d  = 1'b0;
          // Shift on the falling edge so mosi only moves while sclk is low.
          // Zeros fill from the bottom, so after the last bit mosi reads 0.
          tx_d    = {tx_q[p_nbits-2:0], 1'b0};
          mosi_d  = tx_q[p_nbits-2];
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (half_done) begin
          cnt_d = '0;
          if (bit_q == NBITS) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            sclk_d  = 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          resp_val_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_RESP: begin
        if (resp_rdy) begin
          resp_val_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      resp_val_q <= resp_val_d;
    end
  end

endmodule
